// File: rtl/fetch_pkg.sv
// Shared opcodes, default widths and the fetch-entry record for the fetch stage.
package fetch_pkg;

  localparam int DEFAULT_PC_W    = 8;
  localparam int DEFAULT_INSTR_W = 16;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_BEQ = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1111;

  typedef struct packed {
    logic [DEFAULT_PC_W-1:0]    pc;
    logic [DEFAULT_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with push, pop, flush and occupancy count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  entry_t           wr_entry,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  entry_t           mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1'b1);
    end
  endfunction

  // Storage, pointers and occupancy; flush empties without touching storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= entry_t'({$bits(entry_t){1'b0}});
      end
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= wr_entry;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_r + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, credit-limited imem reads, response FIFO and decode handoff.
// Optional FETCH_JMP_PREDECODE_EN resolves JMP words here instead of in execute.
module instr_fetch_stage
  import fetch_pkg::*;
#(
  parameter int PC_W    = DEFAULT_PC_W,
  parameter int INSTR_W = DEFAULT_INSTR_W,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               stall,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [3:0]         if_opcode,
  output logic [PC_W-1:0]    if_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = $clog2(2 * DEPTH + 1);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [PC_W-1:0]  pc_r, pc_next_s;
  logic [PC_W-1:0]  resp_pc_r, resp_pc_next_s;
  logic [CNT_W-1:0] outstanding_r, outstanding_next_s;
  logic [CNT_W-1:0] drop_cnt_r, drop_cnt_next_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic [SUM_W-1:0] used_s;
  logic             rsp_s, keep_s, jmp_s, redir_s;
  logic             issue_s, push_s, pop_s, valid_s;
  entry_t           push_entry_s, head_s;

  // Responses with nothing outstanding are leftovers from before a reset
  assign rsp_s   = imem_rvalid && (outstanding_r != {CNT_W{1'b0}});
  assign keep_s  = rsp_s && (drop_cnt_r == {CNT_W{1'b0}});
  assign valid_s = (fifo_count_s != {CNT_W{1'b0}});

`ifdef FETCH_JMP_PREDECODE_EN
  assign jmp_s = keep_s && !redirect_valid && (imem_rdata[INSTR_W-1 -: 4] == OP_JMP);
`else
  assign jmp_s = 1'b0;
`endif

  // Handshake decisions; a pop this cycle frees a credit for this cycle's request
  always_comb begin
    redir_s = redirect_valid || jmp_s;
    pop_s   = valid_s && !stall && !redirect_valid;
    push_s  = keep_s && !redir_s;
    used_s  = SUM_W'(outstanding_r) + SUM_W'(fifo_count_s) - SUM_W'(pop_s);
    issue_s = rst_n && !redir_s && (used_s < SUM_W'(DEPTH));
  end

  // Next-state for PC, response-PC tracker and in-flight bookkeeping
  always_comb begin
    pc_next_s          = pc_r;
    resp_pc_next_s     = resp_pc_r;
    drop_cnt_next_s    = drop_cnt_r;
    outstanding_next_s = outstanding_r + CNT_W'(issue_s) - CNT_W'(rsp_s);
    if (redirect_valid) begin
      pc_next_s      = redirect_pc;
      resp_pc_next_s = redirect_pc;
    end else if (jmp_s) begin
      pc_next_s      = imem_rdata[PC_W-1:0];
      resp_pc_next_s = imem_rdata[PC_W-1:0];
    end else begin
      if (issue_s) begin
        pc_next_s = pc_r + PC_W'(1'b1);
      end else begin
        pc_next_s = pc_r;
      end
      if (push_s) begin
        resp_pc_next_s = resp_pc_r + PC_W'(1'b1);
      end else begin
        resp_pc_next_s = resp_pc_r;
      end
    end
    // Every read still in flight after a redirect belongs to the old path
    if (redir_s) begin
      drop_cnt_next_s = outstanding_r - CNT_W'(rsp_s);
    end else if (rsp_s && !keep_s) begin
      drop_cnt_next_s = drop_cnt_r - CNT_W'(1'b1);
    end else begin
      drop_cnt_next_s = drop_cnt_r;
    end
  end

  // Fetch state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r          <= {PC_W{1'b0}};
      resp_pc_r     <= {PC_W{1'b0}};
      outstanding_r <= {CNT_W{1'b0}};
      drop_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      pc_r          <= pc_next_s;
      resp_pc_r     <= resp_pc_next_s;
      outstanding_r <= outstanding_next_s;
      drop_cnt_r    <= drop_cnt_next_s;
    end
  end

  assign push_entry_s.pc    = resp_pc_r;
  assign push_entry_s.instr = imem_rdata;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_s),
    .pop      (pop_s),
    .flush    (redirect_valid),
    .wr_entry (push_entry_s),
    .head     (head_s),
    .count    (fifo_count_s)
  );

  assign imem_req  = issue_s;
  assign imem_addr = pc_r;
  assign if_valid  = valid_s;
  assign if_instr  = valid_s ? head_s.instr : {INSTR_W{1'b0}};
  assign if_pc     = valid_s ? head_s.pc : {PC_W{1'b0}};
  assign if_opcode = if_instr[INSTR_W-1 -: 4];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage with a latency-1/2 in-order memory model.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [3:0]  if_opcode;
  logic [7:0]  if_pc;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  bit jmp_mode = 1'b0;
  int inflight;

  logic [3:0] pv = 4'b0000;
  logic [7:0] pa [4];

  logic [7:0] seen_pc [4];
  logic [7:0] exp_pc  [4];
  int         nseen;
  bit         saw_jmp;
  bit         exp_jmp;

  instr_fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_opcode      (if_opcode),
    .if_pc          (if_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [7:0] a, input bit jm);
    if (jm && a == 8'd3) return 16'hF020;
    return {8'h01, a};
  endfunction

  // In-order memory: a request shows up lat cycles later
  always @(posedge clk) begin
    pv    <= {pv[2:0], imem_req};
    pa[0] <= imem_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
  end

  assign imem_rvalid = pv[lat-1];
  assign imem_rdata  = mem_word(pa[lat-1], jmp_mode);

  // Memory-side count of requests not yet answered
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 0;
    else inflight <= inflight + int'(imem_req) - ((imem_rvalid && inflight > 0) ? 1 : 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_req",    32'(imem_req),  32'h0);
    check("rst_addr",   32'(imem_addr), 32'h0);
    check("rst_valid",  32'(if_valid),  32'h0);
    check("rst_instr",  32'(if_instr),  32'h0);
    check("rst_opcode", 32'(if_opcode), 32'h0);
    check("rst_pc",     32'(if_pc),     32'h0);

    // streaming, latency 1
    rst_n = 1'b1;
    #1;
    check("c0_req",  32'(imem_req),  32'h1);
    check("c0_addr", 32'(imem_addr), 32'h0);
    @(negedge clk);
    check("c1_valid", 32'(if_valid),  32'h0);
    check("c1_addr",  32'(imem_addr), 32'h1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stream_valid", 32'(if_valid), 32'h1);
      check("stream_pc",    32'(if_pc),    32'(k));
      check("stream_instr", 32'(if_instr), 32'h0100 + 32'(k));
    end

    // stall for five cycles while pc 4 is presented
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_pc",       32'(if_pc),          32'h4);
      check("stall_valid",    32'(if_valid),       32'h1);
      check("stall_req",      32'(imem_req),       32'h0);
      check("stall_inflight", 32'(inflight <= 2),  32'h1);
    end
    stall = 1'b0;
    @(negedge clk);
    check("resume_pc5",    32'(if_pc),    32'h5);
    check("resume_instr5", 32'(if_instr), 32'h0105);
    @(negedge clk);
    check("resume_pc6", 32'(if_pc), 32'h6);

    // redirect together with a response and stall
    redirect_valid = 1'b1;
    redirect_pc    = 8'h80;
    stall          = 1'b1;
    #1;
    check("redir_noreq", 32'(imem_req), 32'h0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    stall          = 1'b0;
    @(negedge clk);
    check("bubble_valid",  32'(if_valid),  32'h0);
    check("bubble_instr",  32'(if_instr),  32'h0);
    check("bubble_opcode", 32'(if_opcode), 32'h0);
    check("bubble_pc",     32'(if_pc),     32'h0);
    check("target_req",    32'(imem_req),  32'h1);
    check("target_addr",   32'(imem_addr), 32'h80);
    @(negedge clk);
    check("n2_valid", 32'(if_valid), 32'h0);
    @(negedge clk);
    check("n3_valid", 32'(if_valid), 32'h1);
    check("n3_pc",    32'(if_pc),    32'h80);
    check("n3_instr", 32'(if_instr), 32'h0180);
    @(negedge clk);
    check("n4_pc", 32'(if_pc), 32'h81);

    // JMP word at address 3
    rst_n    = 1'b0;
    jmp_mode = 1'b1;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    nseen   = 0;
    saw_jmp = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_valid) begin
        if (nseen < 4) seen_pc[nseen] = if_pc;
        nseen++;
        if (if_opcode == 4'hF) saw_jmp = 1'b1;
      end
    end
`ifdef FETCH_JMP_PREDECODE_EN
    exp_pc  = '{8'h00, 8'h01, 8'h02, 8'h20};
    exp_jmp = 1'b0;
`else
    exp_pc  = '{8'h00, 8'h01, 8'h02, 8'h03};
    exp_jmp = 1'b1;
`endif
    check("jmp_count", 32'(nseen >= 4), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("jmp_seq_pc", 32'(seen_pc[i]), 32'(exp_pc[i]));
    end
    check("jmp_opcode_seen", 32'(saw_jmp), 32'(exp_jmp));

    // latency 2: redirect with two reads in flight
    rst_n    = 1'b0;
    jmp_mode = 1'b0;
    lat      = 2;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("l2_inflight", 32'(inflight), 32'h2);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    #1;
    check("l2_redir_noreq", 32'(imem_req), 32'h0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("l2_stale_dropped", 32'(if_valid), 32'h0);
    end
    @(negedge clk);
    check("l2_target_valid", 32'(if_valid), 32'h1);
    check("l2_target_pc",    32'(if_pc),    32'h40);
    check("l2_target_instr", 32'(if_instr), 32'h0140);
    @(negedge clk);
    check("l2_next_pc", 32'(if_pc), 32'h41);

    // reset pulse with two reads in flight
    @(negedge clk);
    check("pulse_inflight", 32'(inflight), 32'h2);
    rst_n = 1'b0;
    #1;
    check("pulse_valid", 32'(if_valid),  32'h0);
    check("pulse_instr", 32'(if_instr),  32'h0);
    check("pulse_pc",    32'(if_pc),     32'h0);
    check("pulse_req",   32'(imem_req),  32'h0);
    check("pulse_addr",  32'(imem_addr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("pulse_first_req",  32'(imem_req),  32'h1);
    check("pulse_first_addr", 32'(imem_addr), 32'h0);
    @(negedge clk);
    check("pulse_late_ignored1", 32'(if_valid), 32'h0);
    @(negedge clk);
    check("pulse_late_ignored2", 32'(if_valid), 32'h0);
    @(negedge clk);
    check("pulse_restart_valid", 32'(if_valid), 32'h1);
    check("pulse_restart_pc",    32'(if_pc),    32'h0);
    check("pulse_restart_instr", 32'(if_instr), 32'h0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
